board_io: RTL and testbench
===========================

Name: board_io

Overview:
- Parametrised board I/O peripheral for the SoC; replaces the direct switch and LED wiring.
- Synchronises and debounces N_SW slide switches, latches sticky rising-edge flags and raises an interrupt.
- Drives N_LED LEDs in static or blink mode from a small register file on the core's single-cycle memory bus.
- Sits on the SoC peripheral bus, next to the timer.

Parameters:
- N_SW, 8, number of switch inputs (1..32)
- N_LED, 8, number of LED outputs (1..32)
- DEB_CYCLES, 16, consecutive stable cycles needed to accept a switch change (>=2)
- DIV_W, 24, width of blink prescaler register/counter

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req  in  1  bus access strobe, one cycle
- we  in  1  1=write, 0=read
- addr  in  3  word address (byte addr[4:2])
- wdata  in  32  write data
- rdata  out  32  read data, valid with ack
- ack  out  1  one-cycle acknowledge
- sw  in  N_SW  raw asynchronous switch inputs
- led  out  N_LED  LED drive, active-high
- irq  out  1  level interrupt

Behaviour:
- Reset: rstn low forces every flop to 0 immediately; reset is released synchronously through rstn only, no extra stretch. While in reset: led=0, rdata=0, ack=0, irq=0, sw_db=0, edge=0, blink phase=0, prescaler=0.
- Bus:
  - ack is asserted exactly the cycle after req, for one cycle. Back-to-back req in consecutive cycles is legal; each gets its own ack.
  - Writes take effect at the clock edge that samples req.
  - rdata is registered; it holds its last value when ack=0.
  - Unmapped addresses: reads return 0, writes are ignored, ack still asserted.
- Register map (word index):
  - 0 LED_OUT, RW, [N_LED-1:0]
  - 1 SW_IN, RO, debounced switch value
  - 2 LED_MODE, RW, per-LED: 1=blink, 0=static
  - 3 BLINK_DIV, RW, [DIV_W-1:0]
  - 4 SW_EDGE, RO/W1C, sticky rising-edge flags
  - 5 IRQ_MASK, RW, [N_SW-1:0]
  - Unused upper bits read 0.
- Switch path:
  - 2-flop synchroniser per bit, then a per-bit counter.
  - If the synced value equals sw_db, the counter is cleared. Otherwise the counter increments.
  - When the counter reaches DEB_CYCLES-1 while still differing, sw_db takes the synced value and the counter clears.
  - Total latency from a clean input change to SW_IN = 2 + DEB_CYCLES cycles.
  - A glitch shorter than DEB_CYCLES is rejected.
- Edge flags:
  - edge[i] sets on a 0->1 change of sw_db[i].
  - A write to SW_EDGE clears the bits written as 1.
  - A set and a clear of the same bit in the same cycle: set wins.
- irq = |(edge & IRQ_MASK), registered, one cycle after edge/mask change.
- Blink:
  - Prescaler counts 0..BLINK_DIV; on reaching BLINK_DIV it wraps to 0 and toggles phase.
  - BLINK_DIV=0 toggles phase every cycle.
  - A write to BLINK_DIV resets prescaler to 0; phase is unchanged.
- led (registered) = LED_OUT & (~LED_MODE | {N_LED{phase}}), so there is 1 cycle from a register write to the pin.
- Reset mid-operation: debounce counters and in-flight acks are discarded; no ack is produced for a req that coincided with reset.

Decomposition:
- Shared package/header inc/define.vh: register word indices (BIO_LED_OUT..BIO_IRQ_MASK) and the bus data width constant.
- One sub-module: debounce_bit, holding the synchroniser, counter and stable output for a single bit, with parameter DEB_CYCLES. It is instantiated N_SW times via generate.

Test Plan:
- Reset: hold rstn=0 with sw=8'hFF -> led=0, irq=0, ack=0. Release; after 18 cycles, read SW_IN returns 0x000000FF.
- Debounce: sw[0] 0->1 pulse of 10 cycles -> SW_IN stays 0, edge=0. Hold it for 20 cycles -> SW_IN bit0=1 exactly 18 cycles after the change, SW_EDGE=0x1.
- IRQ/W1C: IRQ_MASK=0x1, sw[0] rising -> irq=1. Write SW_EDGE=0x1 -> irq=0 two cycles after the write req. A new rise coinciding with the clear write -> flag stays 1.
- Static LEDs: write LED_OUT=0xA5 -> led=0xA5 one cycle later, ack one cycle after req. Read LED_OUT -> 0x000000A5.
- Blink: LED_OUT=0xFF, LED_MODE=0x0F, BLINK_DIV=3 -> led[3:0] toggles every 4 cycles, led[7:4]=0xF constant. BLINK_DIV=0 -> toggles every cycle.
- Bus edge cases: read addr 7 -> rdata=0, ack=1. Write addr 1 (SW_IN) ignored. Three back-to-back reqs -> three consecutive acks with correct rdata.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O peripheral: bus geometry and the
// register word map seen by software.
package board_io_pkg;

  localparam int BUS_W  = 32;
  localparam int ADDR_W = 3;

  // Word indices of the register file (byte address bits [4:2]).
  typedef enum logic [ADDR_W-1:0] {
    BIO_LED_OUT   = 3'd0,
    BIO_SW_IN     = 3'd1,
    BIO_LED_MODE  = 3'd2,
    BIO_BLINK_DIV = 3'd3,
    BIO_SW_EDGE   = 3'd4,
    BIO_IRQ_MASK  = 3'd5
  } bio_reg_e;

endpackage

// File: rtl/board_io_if.sv
// Single-cycle peripheral bus: one-cycle req strobe, registered ack/rdata
// returned the following cycle.
interface board_io_if;
  import board_io_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  wdata;
  logic [BUS_W-1:0]  rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/board_io_debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a stability counter.
// The stable output only follows the synchronised input after it has
// differed for DEB_CYCLES consecutive cycles.
module debounce_bit #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The counter has seen DEB_CYCLES-1 differing cycles and this is the last.
  assign accept = (sync2 != dout) && (cnt == CNT_LAST);
  // Pulses in the same cycle dout is about to go 0->1.
  assign rise   = accept && sync2;

  // Synchronise the raw pin, then count consecutive cycles of disagreement.
  // NOTE: every flop here is updated with <=, so all right-hand sides see
  // pre-edge values and sync1->sync2 forms a real two-stage chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (accept) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_io.sv
// Board I/O peripheral: debounced switches with sticky rising-edge flags and
// a masked level interrupt, plus LEDs driven statically or from a blink
// prescaler, all exposed through a small register file.
module board_io
  import board_io_pkg::*;
#(
  parameter int N_SW       = 8,
  parameter int N_LED      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int DIV_W      = 24
) (
  input  logic             clk,
  input  logic             rstn,
  board_io_if.slave        bus,
  input  logic [N_SW-1:0]  sw,
  output logic [N_LED-1:0] led,
  output logic             irq
);

  logic [N_SW-1:0]  sw_db;
  logic [N_SW-1:0]  sw_rise;
  logic [N_SW-1:0]  sw_edge;
  logic [N_SW-1:0]  irq_mask;
  logic [N_LED-1:0] led_out;
  logic [N_LED-1:0] led_mode;
  logic [DIV_W-1:0] blink_div;
  logic [DIV_W-1:0] presc;
  logic             phase;

  logic             wr_en;
  logic             rd_en;
  logic             wr_led_out;
  logic             wr_led_mode;
  logic             wr_blink_div;
  logic             wr_sw_edge;
  logic             wr_irq_mask;
  logic [BUS_W-1:0] rd_word;
  logic             unused_wdata;

  // Upper write-data bits beyond each register's width are intentionally dropped.
  assign unused_wdata = ^bus.wdata;

  assign wr_en        = bus.req & bus.we;
  assign rd_en        = bus.req & ~bus.we;
  assign wr_led_out   = wr_en && (bus.addr == BIO_LED_OUT);
  assign wr_led_mode  = wr_en && (bus.addr == BIO_LED_MODE);
  assign wr_blink_div = wr_en && (bus.addr == BIO_BLINK_DIV);
  assign wr_sw_edge   = wr_en && (bus.addr == BIO_SW_EDGE);
  assign wr_irq_mask  = wr_en && (bus.addr == BIO_IRQ_MASK);

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rstn (rstn),
      .din  (sw[i]),
      .dout (sw_db[i]),
      .rise (sw_rise[i])
    );
  end

  // Read mux: zero-extend each register; unmapped words read as zero.
  // NOTE: rd_word gets a full default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_word = '0;
    case (bus.addr)
      BIO_LED_OUT:   rd_word[N_LED-1:0] = led_out;
      BIO_SW_IN:     rd_word[N_SW-1:0]  = sw_db;
      BIO_LED_MODE:  rd_word[N_LED-1:0] = led_mode;
      BIO_BLINK_DIV: rd_word[DIV_W-1:0] = blink_div;
      BIO_SW_EDGE:   rd_word[N_SW-1:0]  = sw_edge;
      BIO_IRQ_MASK:  rd_word[N_SW-1:0]  = irq_mask;
      default:       rd_word = '0;
    endcase
  end

  // Bus response: ack every request one cycle later; rdata only moves on reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack <= bus.req;
      if (rd_en) begin
        bus.rdata <= rd_word;
      end
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_out   <= '0;
      led_mode  <= '0;
      blink_div <= '0;
      irq_mask  <= '0;
    end else begin
      if (wr_led_out)   led_out   <= bus.wdata[N_LED-1:0];
      if (wr_led_mode)  led_mode  <= bus.wdata[N_LED-1:0];
      if (wr_blink_div) blink_div <= bus.wdata[DIV_W-1:0];
      if (wr_irq_mask)  irq_mask  <= bus.wdata[N_SW-1:0];
    end
  end

  // Sticky edge flags (write-one-to-clear, a same-cycle rise wins) and irq.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_edge <= '0;
      irq     <= 1'b0;
    end else begin
      sw_edge <= (sw_edge & ~(wr_sw_edge ? bus.wdata[N_SW-1:0] : '0)) | sw_rise;
      irq     <= |(sw_edge & irq_mask);
    end
  end

  // Blink prescaler: wraps after reaching blink_div and flips the phase;
  // rewriting the divider restarts the count without touching the phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc <= '0;
      phase <= 1'b0;
    end else if (wr_blink_div) begin
      presc <= '0;
    end else if (presc == blink_div) begin
      presc <= '0;
      phase <= ~phase;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Registered LED drive: blink-mode bits are gated by the phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led <= '0;
    end else begin
      led <= led_out & (~led_mode | {N_LED{phase}});
    end
  end

endmodule

// File: tb/tb_board_io.sv
// Directed-plus-random bench for board_io. Expected values come from a small
// register-level model (shadow registers, debounce acceptance by pulse length,
// blink phase from elapsed cycles divided by the period).
module tb_board_io;
  import board_io_pkg::*;

  localparam int N_SW  = 8;
  localparam int N_LED = 8;
  localparam int DEB   = 16;
  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N_SW-1:0]  sw;
  logic [N_LED-1:0] led;
  logic             irq;

  board_io_if bif ();

  board_io #(
    .N_SW(N_SW), .N_LED(N_LED), .DEB_CYCLES(DEB), .DIV_W(DIV_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif),
    .sw   (sw),
    .led  (led),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0]  m_led_out, m_mode, m_mask, m_edge, m_db;
  logic [23:0] m_div;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_led_out = '0; m_mode = '0; m_mask = '0; m_edge = '0; m_db = '0; m_div = '0;
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      BIO_LED_OUT:   m_led_out = d[7:0];
      BIO_LED_MODE:  m_mode    = d[7:0];
      BIO_BLINK_DIV: m_div     = d[23:0];
      BIO_SW_EDGE:   m_edge    = m_edge & ~d[7:0];
      BIO_IRQ_MASK:  m_mask    = d[7:0];
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      BIO_LED_OUT:   return {24'h0, m_led_out};
      BIO_SW_IN:     return {24'h0, m_db};
      BIO_LED_MODE:  return {24'h0, m_mode};
      BIO_BLINK_DIV: return {8'h0, m_div};
      BIO_SW_EDGE:   return {24'h0, m_edge};
      BIO_IRQ_MASK:  return {24'h0, m_mask};
      default:       return 32'h0;
    endcase
  endfunction

  // Switches have been stable long enough to be accepted.
  function automatic void model_sw_settle(input logic [7:0] v);
    m_edge = m_edge | (v & ~m_db);
    m_db   = v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bif.req = 1'b1; bif.we = 1'b1; bif.addr = a; bif.wdata = d;
    tick();
    bif.req = 1'b0; bif.we = 1'b0;
    check("ack_wr", 32'(bif.ack), 32'h1);
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bif.req = 1'b1; bif.we = 1'b0; bif.addr = a;
    tick();
    bif.req = 1'b0;
    check("ack_rd", 32'(bif.ack), 32'h1);
    d = bif.rdata;
  endtask

  task automatic read_check(input logic [2:0] a, input string tag);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, model_read(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          len, b, first, div, n;
    logic [7:0]  out, mode, exp_led;
    logic        ph0, ph, exp_irq;
    logic [2:0]  a;

    model_reset();
    bif.req = 1'b0; bif.we = 1'b0; bif.addr = '0; bif.wdata = '0;
    sw = 8'hFF; rstn = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("rst_led", 32'(led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ack", 32'(bif.ack), 32'h0);
    check("rst_rdata", bif.rdata, 32'h0);

    // Release; switches held high become visible 2+DEB edges later.
    rstn = 1'b1;
    repeat (DEB + 1) tick();
    bus_read(BIO_SW_IN, d);           // sampled on edge 2+DEB: still old
    check("sw_in_pre_accept", d, 32'h0);
    model_sw_settle(8'hFF);
    read_check(BIO_SW_IN, "sw_in_after_rst");
    read_check(BIO_SW_EDGE, "edge_after_rst");
    check("irq_masked", 32'(irq), 32'h0);

    // Drop all switches and clear the flags.
    sw = 8'h00;
    repeat (DEB + 4) tick();
    model_sw_settle(8'h00);
    bus_write(BIO_SW_EDGE, 32'hFF);
    read_check(BIO_SW_EDGE, "edge_w1c_all");
    read_check(BIO_SW_IN, "sw_in_low");

    // Short glitches are rejected; pulses of at least DEB cycles are accepted.
    for (int t = 0; t < 6; t++) begin
      if (t == 0)      len = 10;
      else if (t < 3)  len = $urandom_range(1, DEB - 1);
      else if (t == 3) len = DEB;
      else             len = $urandom_range(DEB, DEB + 6);
      b = (t == 0) ? 0 : $urandom_range(0, 7);
      sw[b] = 1'b1;
      repeat (len) tick();
      sw[b] = 1'b0;
      repeat (DEB + 4) tick();
      if (len >= DEB) m_edge[b] = 1'b1;
      read_check(BIO_SW_IN, "pulse_sw_in");
      read_check(BIO_SW_EDGE, "pulse_edge");
      bus_write(BIO_SW_EDGE, 32'hFF);
    end

    // Exact acceptance latency: read k samples on edge k after the change,
    // the value lands on edge 2+DEB, so read 3+DEB is the first to see it.
    sw[0] = 1'b1;
    first = 0;
    for (int k = 1; k <= DEB + 8; k++) begin
      bus_read(BIO_SW_IN, d);
      if (first == 0 && d[0]) first = k;
    end
    check("deb_latency", 32'(first), 32'(DEB + 3));
    model_sw_settle(8'h01);
    read_check(BIO_SW_EDGE, "edge_bit0");

    // Interrupt follows edge & mask one cycle later.
    bus_write(BIO_IRQ_MASK, 32'h1);
    check("irq_before_mask", 32'(irq), 32'h0);
    tick();
    check("irq_set", 32'(irq), 32'h1);
    bus_write(BIO_SW_EDGE, 32'h1);
    check("irq_hold_on_clear", 32'(irq), 32'h1);
    tick();
    check("irq_cleared", 32'(irq), 32'h0);

    // A rise landing on the same edge as the clearing write keeps the flag.
    sw[0] = 1'b0;
    repeat (DEB + 4) tick();
    model_sw_settle(8'h00);
    sw[0] = 1'b1;
    repeat (DEB + 1) tick();
    bus_write(BIO_SW_EDGE, 32'h1);    // sampled on the acceptance edge
    model_sw_settle(8'h01);
    read_check(BIO_SW_EDGE, "set_wins");
    check("irq_after_set_wins", 32'(irq), 32'h1);
    bus_write(BIO_SW_EDGE, 32'hFF);
    bus_write(BIO_IRQ_MASK, 32'h0);

    // Static LEDs: pin follows one cycle after the write.
    bus_write(BIO_LED_OUT, 32'hA5);
    check("led_before", 32'(led), 32'h0);
    tick();
    check("led_static", 32'(led), 32'hA5);
    read_check(BIO_LED_OUT, "led_out_rd");

    // Blink: after a divider write at edge W, phase after W+j is the old
    // phase flipped floor(j/(div+1)) times; the pin lags the phase by one.
    for (int t = 0; t < 5; t++) begin
      if (t == 0)      begin out = 8'hFF; mode = 8'h0F; div = 3; end
      else if (t == 1) begin out = 8'hFF; mode = 8'h0F; div = 0; end
      else begin
        mode = 8'($urandom_range(1, 255));
        out  = 8'($urandom) | mode;
        div  = $urandom_range(0, 5);
      end
      bus_write(BIO_LED_OUT, 32'(out));
      bus_write(BIO_LED_MODE, 32'(mode));
      bus_write(BIO_BLINK_DIV, 32'(div));
      n = 4 * (div + 1) + 2;
      ph0 = 1'b0;
      for (int k = 1; k <= n; k++) begin
        tick();
        if (k == 1) ph0 = |(led & mode);   // phase left over from before
        ph = ph0 ^ ((((k - 1) / (div + 1)) % 2) != 0);
        exp_led = out & (~mode | {8{ph}});
        check("led_blink", 32'(led), 32'(exp_led));
      end
      read_check(BIO_BLINK_DIV, "blink_div_rd");
    end

    // Bus corner cases.
    read_check(BIO_LED_MODE, "mode_rd");
    read_check(3'd7, "unmapped_rd7");
    read_check(3'd6, "unmapped_rd6");
    bus_write(BIO_SW_IN, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    read_check(BIO_SW_IN, "sw_in_ro");
    tick();
    check("ack_idle", 32'(bif.ack), 32'h0);
    check("rdata_hold", bif.rdata, model_read(BIO_SW_IN));
    bus_write(BIO_LED_OUT, 32'hFFFF_FFFF);
    read_check(BIO_LED_OUT, "upper_bits_zero");
    bus_write(BIO_IRQ_MASK, 32'h3C);
    read_check(BIO_IRQ_MASK, "wr_then_rd");
    read_check(BIO_LED_OUT, "b2b_0");
    read_check(BIO_BLINK_DIV, "b2b_1");
    read_check(BIO_LED_MODE, "b2b_2");
    tick();
    check("ack_after_b2b", 32'(bif.ack), 32'h0);

    // Random traffic with several edge flags live.
    sw = 8'h5B;
    repeat (DEB + 4) tick();
    model_sw_settle(8'h5B);
    for (int t = 0; t < 60; t++) begin
      exp_irq = |(m_edge & m_mask);
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) bus_write(a, $urandom);
      else                           read_check(a, "rand_rd");
      check("rand_irq", 32'(irq), 32'(exp_irq));
    end

    // Reset mid-operation: a request coinciding with reset gets no ack.
    bif.req = 1'b1; bif.we = 1'b1; bif.addr = BIO_LED_OUT; bif.wdata = 32'hFF;
    rstn = 1'b0;
    #1;
    check("midrst_led", 32'(led), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_rdata", bif.rdata, 32'h0);
    tick();
    check("midrst_ack", 32'(bif.ack), 32'h0);
    bif.req = 1'b0; bif.we = 1'b0;
    rstn = 1'b1;
    tick();
    check("no_ack_after_rst", 32'(bif.ack), 32'h0);
    model_reset();
    read_check(BIO_LED_OUT, "led_out_after_rst");
    read_check(BIO_IRQ_MASK, "mask_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
